// File: rtl/tdm_demux_4ch.sv
// 4-channel TDM receiver: deserializes WIDTH-bit MSB-first slots into channel
// registers, tracking frame alignment with a HUNT/LOCKED sync FSM.

module tdm_demux_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  output logic [WIDTH-1:0] q,
  output logic             vld
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      vld <= 1'b0;
    end else begin
      vld <= load;
      if (load) q <= word;
    end
  end
endmodule

module tdm_demux_4ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             in_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] ch0,
  output logic [WIDTH-1:0] ch1,
  output logic [WIDTH-1:0] ch2,
  output logic [WIDTH-1:0] ch3,
  output logic [3:0]       ch_valid,
  output logic             locked,
  output logic             sync_err
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t                     state;
  logic [WIDTH-1:0]           sreg;
  logic [CW-1:0]              bit_cnt;
  logic [1:0]                 slot_cnt;
  logic                       frame_start, normal, last_bit;
  logic [WIDTH-1:0]           word;
  logic [3:0]                 load;
  logic [3:0][WIDTH-1:0]      ch_q;

  assign frame_start = (slot_cnt == 2'd0) && (bit_cnt == '0);
  // A bit is "normal" when the sync marker agrees with our notion of frame start.
  assign normal      = in_valid && (state == LOCKED) && (frame_start == frame_sync);
  assign last_bit    = (bit_cnt == CW'(WIDTH - 1));
  assign word        = {sreg[WIDTH-2:0], din};
  assign locked      = (state == LOCKED);

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign load[k] = normal && last_bit && (slot_cnt == 2'(k));
    tdm_demux_lane #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .word  (word),
      .q     (ch_q[k]),
      .vld   (ch_valid[k])
    );
  end

  assign ch0 = ch_q[0];
  assign ch1 = ch_q[1];
  assign ch2 = ch_q[2];
  assign ch3 = ch_q[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      sreg     <= '0;
      bit_cnt  <= '0;
      slot_cnt <= '0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      if (in_valid) begin
        case (state)
          HUNT: begin
            if (frame_sync) begin
              sreg     <= word;
              bit_cnt  <= CW'(1);
              slot_cnt <= '0;
              state    <= LOCKED;
            end
          end
          LOCKED: begin
            if (frame_start && !frame_sync) begin
              sync_err <= 1'b1;
              bit_cnt  <= '0;
              slot_cnt <= '0;
              state    <= HUNT;
            end else if (!frame_start && frame_sync) begin
              // Early sync: drop the partial slot and restart the frame on this bit.
              sync_err <= 1'b1;
              sreg     <= word;
              bit_cnt  <= CW'(1);
              slot_cnt <= '0;
            end else begin
              sreg <= word;
              if (last_bit) begin
                bit_cnt  <= '0;
                slot_cnt <= slot_cnt + 2'd1;
              end else begin
                bit_cnt  <= bit_cnt + CW'(1);
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Bench for tdm_demux_4ch: frame-level reference model checked every cycle,
// plus directed scenarios with literal expectations.

module tb_tdm_demux_4ch;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         din = 1'b0, in_valid = 1'b0, frame_sync = 1'b0;
  logic [W-1:0] ch0, ch1, ch2, ch3;
  logic [3:0]   ch_valid;
  logic         locked, sync_err;

  tdm_demux_4ch #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid), .frame_sync(frame_sync),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
    .ch_valid(ch_valid), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int vecs = 0, miss = 0;
  int cyc = 0, err_cnt = 0, ch2_pulses = 0;
  int pulse_q[$];
  bit chk_en = 1'b0;

  // Reference model: bits received since the last frame start, as a list.
  bit           m_locked;
  bit           m_frame[$];
  logic [W-1:0] m_ch[4];
  logic [3:0]   m_vld;
  bit           m_err;
  int           m_slot;
  logic [W-1:0] m_word;

  always @(posedge clk or negedge rst_n) begin
    m_vld = '0;
    m_err = 1'b0;
    if (!rst_n) begin
      m_locked = 1'b0;
      m_frame.delete();
      for (int i = 0; i < 4; i++) m_ch[i] = '0;
    end else if (in_valid) begin
      if (!m_locked) begin
        if (frame_sync) begin
          m_frame.delete();
          m_frame.push_back(din);
          m_locked = 1'b1;
        end
      end else if (m_frame.size() == 0 && !frame_sync) begin
        m_err    = 1'b1;
        m_locked = 1'b0;
      end else if (m_frame.size() != 0 && frame_sync) begin
        m_err = 1'b1;
        m_frame.delete();
        m_frame.push_back(din);
      end else begin
        m_frame.push_back(din);
        if (m_frame.size() % W == 0) begin
          m_slot = m_frame.size() / W - 1;
          for (int i = 0; i < W; i++) m_word[W-1-i] = m_frame[m_slot*W + i];
          m_ch[m_slot]  = m_word;
          m_vld[m_slot] = 1'b1;
          if (m_frame.size() == 4*W) m_frame.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vecs++;
      if (ch0 !== m_ch[0] || ch1 !== m_ch[1] || ch2 !== m_ch[2] || ch3 !== m_ch[3] ||
          ch_valid !== m_vld || locked !== m_locked || sync_err !== m_err) begin
        miss++;
        $display("FAIL model cyc%0d: got ch=%h/%h/%h/%h v=%b l=%b e=%b expected ch=%h/%h/%h/%h v=%b l=%b e=%b",
                 cyc, ch0, ch1, ch2, ch3, ch_valid, locked, sync_err,
                 m_ch[0], m_ch[1], m_ch[2], m_ch[3], m_vld, m_locked, m_err);
      end
      if (ch_valid != 4'b0) pulse_q.push_back(cyc);
      if (ch_valid[2]) ch2_pulses++;
      if (sync_err) err_cnt++;
    end
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic d, input logic fs);
    @(negedge clk);
    din = d; frame_sync = fs; in_valid = 1'b1;
  endtask

  // Gap cycle with junk on the data/sync lines, which must be ignored.
  task automatic gap();
    @(negedge clk);
    in_valid = 1'b0; din = 1'b1; frame_sync = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; frame_sync = 1'b0; din = 1'b0;
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic fs0, input bit gapped);
    for (int i = W-1; i >= 0; i--) begin
      send_bit(w[i], fs0 && (i == W-1));
      if (gapped) gap();
    end
  endtask

  task automatic send_frame(input logic [4*W-1:0] f, input bit gapped);
    send_word(f[4*W-1:3*W], 1'b1, gapped);
    send_word(f[3*W-1:2*W], 1'b0, gapped);
    send_word(f[2*W-1:W],   1'b0, gapped);
    send_word(f[W-1:0],     1'b0, gapped);
  endtask

  task automatic clear_stats();
    pulse_q.delete();
    err_cnt = 0;
    ch2_pulses = 0;
  endtask

  task automatic check_spacing(input string name, input int n, input int sp);
    check({name, "_count"}, pulse_q.size(), n);
    for (int i = 1; i < pulse_q.size(); i++)
      check({name, "_spacing"}, pulse_q[i] - pulse_q[i-1], sp);
  endtask

  task automatic check_chans(input string name, input logic [4*W-1:0] f);
    check({name, "_ch0"}, ch0, f[4*W-1:3*W]);
    check({name, "_ch1"}, ch1, f[3*W-1:2*W]);
    check({name, "_ch2"}, ch2, f[2*W-1:W]);
    check({name, "_ch3"}, ch3, f[W-1:0]);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ch0", ch0, 0);
    check("rst_ch3", ch3, 0);
    check("rst_locked", locked, 0);
    check("rst_valid", ch_valid, 0);
    check("rst_err", sync_err, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Aligned frame, continuous
    clear_stats();
    send_frame(32'hA5_3C_FF_01, 1'b0);
    idle(2);
    check_chans("frame1", 32'hA5_3C_FF_01);
    check_spacing("frame1_pulse", 4, W);
    check("frame1_locked", locked, 1);
    check("frame1_err", err_cnt, 0);

    // Same frame with every other cycle idle
    clear_stats();
    send_frame(32'hA5_3C_FF_01, 1'b1);
    idle(2);
    check_chans("gapped", 32'hA5_3C_FF_01);
    check_spacing("gapped_pulse", 4, 2*W);
    check("gapped_err", err_cnt, 0);

    // Missing sync at frame start, then relock
    clear_stats();
    send_word(8'hF0, 1'b0, 1'b0);
    idle(2);
    check("nosync_err", err_cnt, 1);
    check("nosync_locked", locked, 0);
    check("nosync_pulses", pulse_q.size(), 0);
    clear_stats();
    send_frame(32'h11_22_33_44, 1'b0);
    idle(2);
    check_chans("relock", 32'h11_22_33_44);
    check("relock_locked", locked, 1);
    check("relock_err", err_cnt, 0);

    // Early sync at bit 4 of slot 2
    clear_stats();
    send_word(8'hDE, 1'b1, 1'b0);
    send_word(8'hAD, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    send_frame(32'h55_66_77_88, 1'b0);
    idle(2);
    check_chans("early", 32'h55_66_77_88);
    check("early_err", err_cnt, 1);
    check("early_locked", locked, 1);
    check("early_ch2_pulses", ch2_pulses, 1);
    check("early_pulses", pulse_q.size(), 6);

    // Reset mid slot 1
    send_word(8'h5A, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("prerst_ch0", ch0, 8'h5A);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_ch0", ch0, 0);
    check("midrst_locked", locked, 0);
    check("midrst_valid", ch_valid, 0);
    idle(2);
    rst_n = 1'b1;

    // HUNT ignores unsynced bits
    clear_stats();
    for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0);
    send_word(8'hC3, 1'b0, 1'b0);
    idle(2);
    check("hunt_locked", locked, 0);
    check("hunt_pulses", pulse_q.size(), 0);
    check("hunt_ch0", ch0, 0);
    check("hunt_err", err_cnt, 0);

    // Model pins: literal values the model itself must hold
    check("model_ch0", m_ch[0], 0);
    check("model_locked", m_locked, 0);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
